// File: rtl/spi_regfile_pkg.sv
// Shared types and command-byte layout for the SPI-sampled register file.
package spi_regfile_pkg;

    localparam int unsigned CMD_W        = 8;
    localparam int unsigned ADDR_W       = 7;
    localparam int unsigned CMD_RW_BIT   = 7;
    localparam int unsigned CMD_ADDR_MSB = 6;
    localparam int unsigned CMD_ADDR_LSB = 0;
    localparam int unsigned CNT_W        = 6;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CMD  = 2'd1,
        ST_DATA = 2'd2
    } state_e;

endpackage

// File: rtl/sync_2ff.sv
// Two-stage synchronizer bank with a per-bit reset (idle) level.
module sync_2ff #(
    parameter int unsigned       WIDTH   = 1,
    parameter logic [WIDTH-1:0]  RST_VAL = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/spi_regfile_sampled.sv
// SPI mode-0 slave register file; SPI pins are oversampled on clk, frames are
// {rw, addr[6:0]} followed by DATA_W-bit data words with auto-increment.
module spi_regfile_sampled
    import spi_regfile_pkg::*;
#(
    parameter int unsigned                NUM_REGS   = 4,
    parameter int unsigned                DATA_W     = 8,
    parameter logic [NUM_REGS*DATA_W-1:0] RESET_VALS = {8'h03, 8'h02, 8'h01, 8'h96}
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sclk,
    input  logic                         mosi,
    input  logic                         cs_n,
    output logic                         miso,
    output logic                         miso_oe,
    output logic [NUM_REGS*DATA_W-1:0]   reg_q,
    output logic                         wr_strobe,
    output logic [ADDR_W-1:0]            wr_addr
);

    logic [2:0] sync_out;
    logic       cs_s, sclk_s, mosi_s;

    sync_2ff #(
        .WIDTH   (3),
        .RST_VAL (3'b100)
    ) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     ({cs_n, sclk, mosi}),
        .q     (sync_out)
    );

    assign {cs_s, sclk_s, mosi_s} = sync_out;

    state_e                      state_q, state_d;
    logic                        sclk_prev_q, sclk_prev_d;
    logic                        cs_prev_q, cs_prev_d;
    logic [1:0]                  warm_q, warm_d;
    logic                        armed_q, armed_d;
    logic [CNT_W-1:0]            bit_cnt_q, bit_cnt_d;
    logic [DATA_W-2:0]           rx_sh_q, rx_sh_d;
    logic [DATA_W-1:0]           tx_sh_q, tx_sh_d;
    logic                        rw_q, rw_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [NUM_REGS*DATA_W-1:0]  regs_q, regs_d;
    logic                        wr_strobe_q, wr_strobe_d;
    logic [ADDR_W-1:0]           wr_addr_q, wr_addr_d;

    logic              sclk_rise, sclk_fall, cs_fall, cs_rise;
    logic [DATA_W-1:0] rx_word;
    logic [CMD_W-1:0]  cmd_byte;
    logic [ADDR_W-1:0] next_addr;

    function automatic logic [DATA_W-1:0] read_reg(
        input logic [NUM_REGS*DATA_W-1:0] img,
        input logic [ADDR_W-1:0]          a
    );
        logic [DATA_W-1:0] w;
        w = '0;
        for (int unsigned i = 0; i < NUM_REGS; i++) begin
            if (32'(a) == i) w = img[i*DATA_W +: DATA_W];
        end
        return w;
    endfunction

    // A falling cs_n is only trusted once a real high level has been seen
    // after reset, so a frame cut by reset cannot be resumed mid-way.
    always_comb begin
        sclk_prev_d = sclk_s;
        cs_prev_d   = cs_s;
        warm_d      = (warm_q == 2'd2) ? warm_q : warm_q + 2'd1;
        armed_d     = armed_q | ((warm_q == 2'd2) & cs_s);
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        cs_fall     = ~cs_s & cs_prev_q & armed_q;
        cs_rise     = cs_s & ~cs_prev_q;
        rx_word     = {rx_sh_q, mosi_s};
        cmd_byte    = {rx_sh_q[CMD_W-2:0], mosi_s};
        next_addr   = ADDR_W'((32'(addr_q) + 32'd1) % NUM_REGS);
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        rx_sh_d     = rx_sh_q;
        tx_sh_d     = tx_sh_q;
        rw_d        = rw_q;
        addr_d      = addr_q;
        regs_d      = regs_q;
        wr_strobe_d = 1'b0;
        wr_addr_d   = wr_addr_q;

        case (state_q)
            ST_IDLE: begin
                if (cs_fall) begin
                    state_d   = ST_CMD;
                    bit_cnt_d = '0;
                    rx_sh_d   = '0;
                    tx_sh_d   = '0;
                end
            end
            ST_CMD: begin
                if (sclk_rise) begin
                    rx_sh_d = {rx_sh_q[DATA_W-3:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(CMD_W - 1)) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = '0;
                        rx_sh_d   = '0;
                        rw_d      = cmd_byte[CMD_RW_BIT];
                        addr_d    = cmd_byte[CMD_ADDR_MSB:CMD_ADDR_LSB];
                        tx_sh_d   = read_reg(regs_q, cmd_byte[CMD_ADDR_MSB:CMD_ADDR_LSB]);
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_DATA: begin
                if (sclk_rise) begin
                    rx_sh_d = {rx_sh_q[DATA_W-3:0], mosi_s};
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        rx_sh_d   = '0;
                        if (rw_q && (32'(addr_q) < NUM_REGS)) begin
                            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                                if (32'(addr_q) == i) regs_d[i*DATA_W +: DATA_W] = rx_word;
                            end
                            wr_strobe_d = 1'b1;
                            wr_addr_d   = addr_q;
                        end
                        addr_d  = next_addr;
                        tx_sh_d = read_reg(regs_q, next_addr);
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end else if (sclk_fall && (bit_cnt_q != '0)) begin
                    // The MSB of a freshly loaded word must survive the
                    // falling edge that precedes its first rising edge.
                    tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (cs_rise) begin
            state_d   = ST_IDLE;
            bit_cnt_d = '0;
            rx_sh_d   = '0;
            tx_sh_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            sclk_prev_q <= 1'b0;
            cs_prev_q   <= 1'b1;
            warm_q      <= '0;
            armed_q     <= 1'b0;
            bit_cnt_q   <= '0;
            rx_sh_q     <= '0;
            tx_sh_q     <= '0;
            rw_q        <= 1'b0;
            addr_q      <= '0;
            regs_q      <= RESET_VALS;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
        end else begin
            state_q     <= state_d;
            sclk_prev_q <= sclk_prev_d;
            cs_prev_q   <= cs_prev_d;
            warm_q      <= warm_d;
            armed_q     <= armed_d;
            bit_cnt_q   <= bit_cnt_d;
            rx_sh_q     <= rx_sh_d;
            tx_sh_q     <= tx_sh_d;
            rw_q        <= rw_d;
            addr_q      <= addr_d;
            regs_q      <= regs_d;
            wr_strobe_q <= wr_strobe_d;
            wr_addr_q   <= wr_addr_d;
        end
    end

    assign miso      = (state_q == ST_DATA) & tx_sh_q[DATA_W-1];
    assign miso_oe   = ~cs_s;
    assign reg_q     = regs_q;
    assign wr_strobe = wr_strobe_q;
    assign wr_addr   = wr_addr_q;

endmodule

// File: tb/tb_spi_regfile_sampled.sv
// Scoreboard bench: two register files (4x8 and 6x16) sharing sclk/mosi with
// separate chip selects; expected reads and writes are queued ahead of stimulus.
module tb_spi_regfile_sampled;

    localparam int unsigned N0 = 4;
    localparam int unsigned W0 = 8;
    localparam int unsigned N1 = 6;
    localparam int unsigned W1 = 16;
    localparam logic [N0*W0-1:0] RV0 = 32'h03020196;
    localparam logic [N1*W1-1:0] RV1 = {16'h5555, 16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'hA0A0};

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic sclk = 1'b0;
    logic mosi = 1'b0;
    logic cs0_n = 1'b1;
    logic cs1_n = 1'b1;

    logic             miso0, miso0_oe, wr0;
    logic             miso1, miso1_oe, wr1;
    logic [N0*W0-1:0] reg0_q;
    logic [N1*W1-1:0] reg1_q;
    logic [6:0]       wa0, wa1;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    spi_regfile_sampled #(
        .NUM_REGS   (N0),
        .DATA_W     (W0),
        .RESET_VALS (RV0)
    ) u_dut0 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs0_n),
        .miso      (miso0),
        .miso_oe   (miso0_oe),
        .reg_q     (reg0_q),
        .wr_strobe (wr0),
        .wr_addr   (wa0)
    );

    spi_regfile_sampled #(
        .NUM_REGS   (N1),
        .DATA_W     (W1),
        .RESET_VALS (RV1)
    ) u_dut1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .sclk      (sclk),
        .mosi      (mosi),
        .cs_n      (cs1_n),
        .miso      (miso1),
        .miso_oe   (miso1_oe),
        .reg_q     (reg1_q),
        .wr_strobe (wr1),
        .wr_addr   (wa1)
    );

    typedef struct {
        int unsigned addr;
        logic [31:0] data;
    } wr_exp_t;

    wr_exp_t     wq0[$];
    wr_exp_t     wq1[$];
    logic [31:0] rq[$];

    int checks = 0;
    int errors = 0;

    bit          sel = 1'b0;
    int          last_rise_cyc = 0;
    logic [31:0] rx_word = '0;
    event        rx_ev;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic push_wr(input bit d, input int unsigned a, input logic [31:0] v);
        wr_exp_t e;
        e.addr = a;
        e.data = v;
        if (d) wq1.push_back(e);
        else   wq0.push_back(e);
    endtask

    task automatic cs_assert();
        @(negedge clk);
        if (sel) cs1_n = 1'b0;
        else     cs0_n = 1'b0;
    endtask

    task automatic cs_release();
        repeat (4) @(negedge clk);
        cs0_n = 1'b1;
        cs1_n = 1'b1;
        mosi  = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Master samples miso just before each rising edge, as a mode-0 master would.
    task automatic xfer(input logic [31:0] tx, input int nbits, input bit chk);
        logic [31:0] rx;
        rx = '0;
        for (int i = nbits - 1; i >= 0; i--) begin
            mosi = tx[i];
            repeat (4) @(negedge clk);
            rx = {rx[30:0], (sel ? miso1 : miso0)};
            sclk = 1'b1;
            last_rise_cyc = cyc;
            repeat (4) @(negedge clk);
            sclk = 1'b0;
        end
        if (chk) begin
            rx_word = rx;
            ->rx_ev;
        end
    endtask

    initial begin : rd_monitor
        logic [31:0] e;
        forever begin
            @(rx_ev);
            if (rq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rd_unexpected actual=%0h required=no word", rx_word);
            end else begin
                e = rq.pop_front();
                check("rd_word", 128'(rx_word), 128'(e));
            end
        end
    end

    initial begin : wr0_monitor
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (wr0 === 1'b1) begin
                if (wq0.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr0_unexpected actual=strobe@%0d required=no strobe", wa0);
                end else begin
                    e = wq0.pop_front();
                    check("wr0_addr", 128'(wa0), 128'(e.addr));
                    check("wr0_data", 128'(reg0_q[e.addr*W0 +: W0]), 128'(e.data));
                    check("wr0_latency_le4", 128'((cyc - last_rise_cyc) <= 4), 128'(1));
                end
            end
        end
    end

    initial begin : wr1_monitor
        wr_exp_t e;
        forever begin
            @(negedge clk);
            if (wr1 === 1'b1) begin
                if (wq1.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL wr1_unexpected actual=strobe@%0d required=no strobe", wa1);
                end else begin
                    e = wq1.pop_front();
                    check("wr1_addr", 128'(wa1), 128'(e.addr));
                    check("wr1_data", 128'(reg1_q[e.addr*W1 +: W1]), 128'(e.data));
                    check("wr1_latency_le4", 128'((cyc - last_rise_cyc) <= 4), 128'(1));
                end
            end
        end
    end

    initial begin : stim
        repeat (3) @(negedge clk);
        check("rst_reg0", 128'(reg0_q), 128'(RV0));
        check("rst_reg1", 128'(reg1_q), 128'(RV1));
        check("rst_wr_addr", 128'(wa0), 128'(0));
        check("rst_wr_strobe", 128'(wr0), 128'(0));
        check("rst_miso", 128'(miso0), 128'(0));
        check("rst_miso_oe", 128'(miso0_oe), 128'(0));
        rst_n = 1'b1;
        repeat (10) @(negedge clk);

        // Default read burst from address 0; command-phase miso must be 0.
        sel = 1'b0;
        rq.push_back(32'h00);
        rq.push_back(32'h96);
        rq.push_back(32'h01);
        rq.push_back(32'h02);
        rq.push_back(32'h03);
        cs_assert();
        xfer(32'h00, 8, 1'b1);
        check("miso_oe_in_frame", 128'(miso0_oe), 128'(1));
        for (int k = 0; k < 4; k++) xfer(32'h00, 8, 1'b1);
        cs_release();
        check("miso_oe_idle", 128'(miso0_oe), 128'(0));

        // Single write addr 2.
        push_wr(1'b0, 2, 32'hA5);
        cs_assert();
        xfer(32'h82, 8, 1'b0);
        xfer(32'hA5, 8, 1'b0);
        cs_release();
        check("img_after_wr2", 128'(reg0_q), 128'(32'h03A50196));

        // Burst write from addr 3 wraps to 0.
        push_wr(1'b0, 3, 32'h11);
        push_wr(1'b0, 0, 32'h22);
        cs_assert();
        xfer(32'h83, 8, 1'b0);
        xfer(32'h11, 8, 1'b0);
        xfer(32'h22, 8, 1'b0);
        cs_release();
        check("img_after_burst", 128'(reg0_q), 128'(32'h11A50122));

        // Partial word: 5 data bits then cs_n high.
        cs_assert();
        xfer(32'h81, 8, 1'b0);
        xfer(32'h1F, 5, 1'b0);
        cs_release();
        check("img_after_partial", 128'(reg0_q), 128'(32'h11A50122));
        check("wr_addr_holds", 128'(wa0), 128'(0));

        // Out-of-range write ignored, out-of-range read returns zero.
        cs_assert();
        xfer(32'hFF, 8, 1'b0);
        xfer(32'h66, 8, 1'b0);
        cs_release();
        check("img_after_oor_wr", 128'(reg0_q), 128'(32'h11A50122));
        rq.push_back(32'h00);
        rq.push_back(32'h00);
        cs_assert();
        xfer(32'h7F, 8, 1'b1);
        xfer(32'h00, 8, 1'b1);
        cs_release();

        // 6x16 instance.
        sel = 1'b1;
        rq.push_back(32'h00);
        rq.push_back(32'h0000);
        cs_assert();
        xfer(32'h07, 8, 1'b1);
        xfer(32'h0000, 16, 1'b1);
        cs_release();
        push_wr(1'b1, 5, 32'hBEEF);
        cs_assert();
        xfer(32'h85, 8, 1'b0);
        xfer(32'hBEEF, 16, 1'b0);
        cs_release();
        rq.push_back(32'h00);
        rq.push_back(32'hBEEF);
        rq.push_back(32'hA0A0);
        cs_assert();
        xfer(32'h05, 8, 1'b1);
        xfer(32'h0000, 16, 1'b1);
        xfer(32'h0000, 16, 1'b1);
        cs_release();
        check("img1_after_wr5", 128'(reg1_q),
              128'({16'hBEEF, 16'h4444, 16'h3333, 16'h2222, 16'h1111, 16'hA0A0}));
        check("wr1_addr_final", 128'(wa1), 128'(5));

        // Reset in the middle of a write frame.
        sel = 1'b0;
        cs_assert();
        xfer(32'h81, 8, 1'b0);
        xfer(32'h5, 4, 1'b0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_reg0", 128'(reg0_q), 128'(RV0));
        check("midrst_wr_addr", 128'(wa0), 128'(0));
        check("midrst_miso_oe", 128'(miso0_oe), 128'(0));
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        xfer(32'hA, 4, 1'b0);
        cs_release();
        check("postrst_reg0", 128'(reg0_q), 128'(RV0));

        rq.push_back(32'h00);
        rq.push_back(32'h96);
        rq.push_back(32'h01);
        rq.push_back(32'h02);
        rq.push_back(32'h03);
        cs_assert();
        xfer(32'h00, 8, 1'b1);
        for (int k = 0; k < 4; k++) xfer(32'h00, 8, 1'b1);
        cs_release();
        push_wr(1'b0, 1, 32'h77);
        cs_assert();
        xfer(32'h81, 8, 1'b0);
        xfer(32'h77, 8, 1'b0);
        cs_release();
        check("postrst_img", 128'(reg0_q), 128'(32'h03027796));
        check("postrst_wr_addr", 128'(wa0), 128'(1));

        for (int k = 0; k < 200; k++) begin
            if (rq.size() == 0 && wq0.size() == 0 && wq1.size() == 0) break;
            @(negedge clk);
        end
        check("rd_queue_drained", 128'(rq.size()), 128'(0));
        check("wr0_queue_drained", 128'(wq0.size()), 128'(0));
        check("wr1_queue_drained", 128'(wq1.size()), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
